// File: rtl/min_pkg.sv
// Shared types and helpers for the streaming min-reduction controller.
// Index tracking is compiled in only when MIN_REDUCE_IDX_EN is defined.
package min_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Index width for an n-entry space; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Most-positive two's complement value of a w-bit element, zero-extended.
  function automatic logic [63:0] max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/min_reduce_ctrl_if.sv
// Beat-in / result-out handshake bundle for min_reduce_ctrl.
// master = producer/consumer side, slave = the controller.
interface min_reduce_ctrl_if import min_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int CHUNK_LEN  = 8,
  parameter int NUM_CHUNKS = 4
) ();
  localparam int IDX_W = idx_w(CHUNK_LEN * NUM_CHUNKS);

  logic                            start;
  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_WIDTH*CHUNK_LEN-1:0] in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_min;
  logic [IDX_W-1:0]                out_idx;
  logic                            busy;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_min, out_idx, busy
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_min, out_idx, busy
  );
endinterface

// File: rtl/chunk_min.sv
// Combinational signed min over one beat of CHUNK_LEN lanes (binary tree).
// With MIN_REDUCE_IDX_EN, also returns the lowest lane holding the minimum.
module chunk_min import min_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int CHUNK_LEN  = 8
) (
  input  logic [DATA_WIDTH*CHUNK_LEN-1:0] in_data,
  output logic signed [DATA_WIDTH-1:0]    min_val
`ifdef MIN_REDUCE_IDX_EN
  ,
  output logic [idx_w(CHUNK_LEN)-1:0]     min_idx
`endif
);
  localparam int LEAVES = 1 << $clog2(CHUNK_LEN);
  localparam logic signed [DATA_WIDTH-1:0] MAX_POS = DATA_WIDTH'(max_pos(DATA_WIDTH));

  // In-place tree: level by level, slot k takes the smaller of slots 2k/2k+1.
  // A tie keeps the left (lower-lane) slot; padding lanes sit right of real ones.
  always_comb begin
    logic signed [DATA_WIDTH-1:0] v [LEAVES];
`ifdef MIN_REDUCE_IDX_EN
    logic [idx_w(CHUNK_LEN)-1:0]  ix [LEAVES];
`endif
    for (int k = 0; k < LEAVES; k++) begin
      v[k] = MAX_POS;
      if (k < CHUNK_LEN) v[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef MIN_REDUCE_IDX_EN
      ix[k] = idx_w(CHUNK_LEN)'(k);
`endif
    end
    for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
      for (int k = 0; k < w; k++) begin
        if (v[2*k+1] < v[2*k]) begin
          v[k] = v[2*k+1];
`ifdef MIN_REDUCE_IDX_EN
          ix[k] = ix[2*k+1];
`endif
        end else begin
          v[k] = v[2*k];
`ifdef MIN_REDUCE_IDX_EN
          ix[k] = ix[2*k];
`endif
        end
      end
    end
    min_val = v[0];
`ifdef MIN_REDUCE_IDX_EN
    min_idx = ix[0];
`endif
  end

endmodule

// File: rtl/min_reduce_ctrl.sv
// Streaming min-reduction controller: one chunk per beat, running min/index, valid/ready result.
// Define MIN_REDUCE_IDX_EN to compile in global index tracking; otherwise out_idx is 0.
module min_reduce_ctrl import min_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int CHUNK_LEN  = 8,
  parameter int NUM_CHUNKS = 4
) (
  input logic             clk,
  input logic             rst,
  min_reduce_ctrl_if.slave bus
);
  localparam int CNT_W = idx_w(NUM_CHUNKS);
  localparam logic signed [DATA_WIDTH-1:0] MAX_POS = DATA_WIDTH'(max_pos(DATA_WIDTH));
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ACCUM = ACCUM;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]                   state_q, state_d;
  logic [CNT_W-1:0]             chunk_cnt_q, chunk_cnt_d;
  logic signed [DATA_WIDTH-1:0] run_min_q, run_min_d;
  logic signed [DATA_WIDTH-1:0] beat_min;
  logic                         beat_take, improve;

  assign beat_take = (state_q == S_ACCUM) && bus.in_valid;
  // Strict less-than keeps the earliest beat on ties.
  assign improve   = beat_take && (beat_min < run_min_q);

`ifdef MIN_REDUCE_IDX_EN
  localparam int IDX_W = idx_w(CHUNK_LEN * NUM_CHUNKS);
  localparam int LOC_W = idx_w(CHUNK_LEN);

  logic [LOC_W-1:0] beat_idx;
  logic [IDX_W-1:0] run_idx_q, run_idx_d, cand_idx;

  chunk_min #(.DATA_WIDTH(DATA_WIDTH), .CHUNK_LEN(CHUNK_LEN)) u_chunk_min (
    .in_data (bus.in_data),
    .min_val (beat_min),
    .min_idx (beat_idx)
  );

  assign cand_idx = IDX_W'(chunk_cnt_q) * IDX_W'(CHUNK_LEN) + IDX_W'(beat_idx);

  always_comb begin
    run_idx_d = run_idx_q;
    if (state_q == S_IDLE && bus.start) run_idx_d = '0;
    else if (improve)                   run_idx_d = cand_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) run_idx_q <= '0;
    else     run_idx_q <= run_idx_d;
  end

  assign bus.out_idx = run_idx_q;
`else
  chunk_min #(.DATA_WIDTH(DATA_WIDTH), .CHUNK_LEN(CHUNK_LEN)) u_chunk_min (
    .in_data (bus.in_data),
    .min_val (beat_min)
  );

  assign bus.out_idx = '0;
`endif

  always_comb begin
    state_d     = state_q;
    chunk_cnt_d = chunk_cnt_q;
    run_min_d   = run_min_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d     = S_ACCUM;
        chunk_cnt_d = '0;
        run_min_d   = MAX_POS;
      end
      S_ACCUM: if (beat_take) begin
        if (improve) run_min_d = beat_min;
        if (chunk_cnt_q == CNT_W'(NUM_CHUNKS - 1)) state_d = S_DONE;
        else                                       chunk_cnt_d = chunk_cnt_q + CNT_W'(1);
      end
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      chunk_cnt_q <= '0;
      run_min_q   <= '0;
    end else begin
      state_q     <= state_d;
      chunk_cnt_q <= chunk_cnt_d;
      run_min_q   <= run_min_d;
    end
  end

  // Every output decodes straight from flops; in_data only reaches the running registers.
  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_ACCUM) || (state_q == S_DONE);
  assign bus.out_min   = run_min_q;

endmodule

// File: doc/min_reduce_ctrl.md
# min_reduce_ctrl

Streaming min-reduction controller for the attention datapath. It sequences a vector of `CHUNK_LEN*NUM_CHUNKS` signed elements through a combinational chunk-min stage, one chunk per beat, and keeps a running minimum and its element index. The final result is presented on a valid/ready output. It sits between the score buffer and the softmax normalisation stage, which consumes the row minimum.

## Interface
- `DATA_WIDTH`, 16: element width, signed two's complement.
- `CHUNK_LEN`, 8: elements per input beat.
- `NUM_CHUNKS`, 4: beats per vector, ≥1.
- `clk` input 1: the single clock.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: begin a new reduction; sampled only in IDLE.
- `in_valid` input 1: `in_data` beat valid.
- `in_ready` output 1: controller accepts a beat.
- `in_data` input `DATA_WIDTH*CHUNK_LEN`: element i at bits `[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_min` output `DATA_WIDTH`: vector minimum.
- `out_idx` output `$clog2(CHUNK_LEN*NUM_CHUNKS)` (min 1): global index of the minimum.
- `busy` output 1: high in ACCUM or DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE → ACCUM on `start`.
  - Clears `chunk_cnt` to 0.
  - Loads the running minimum with the most-positive value, `{1'b0,{DATA_WIDTH-1{1'b1}}}`.
  - Loads the running index with 0.
- ACCUM: `in_ready`=1. A beat is accepted when `in_valid && in_ready`.
  - The chunk-min stage returns the smallest element of the beat and its local index (0..CHUNK_LEN-1).
  - Global candidate index = `chunk_cnt*CHUNK_LEN + local`.
  - Running min and index update only if the candidate is strictly less than the running min.
  - Ties resolve to the lowest global index: lowest lane within a beat, earliest beat across beats.
  - Comparison is signed.
- After the beat with `chunk_cnt == NUM_CHUNKS-1` is accepted → DONE. Otherwise `chunk_cnt` increments.
- DONE: `out_valid`=1. `out_min` and `out_idx` hold stable until `out_valid && out_ready`, then → IDLE.
- Inputs that are ignored:
  - `start` outside IDLE, including `start` coinciding with the DONE handshake.
  - `in_valid` outside ACCUM.
- `rst` in any state aborts the reduction. No partial result is emitted.

## Timing
- Reset values: state IDLE; `in_ready`, `out_valid`, `busy` = 0; `out_min` = 0; `out_idx` = 0.
- `start` sampled at cycle T → `in_ready`=1 at T+1.
- With `in_valid` held high, beats are accepted at T+1 … T+NUM_CHUNKS.
- `out_valid` rises the cycle after the last accepted beat: T+NUM_CHUNKS+1 at full rate.
- `out_valid` handshake at cycle D → IDLE at D+1. The earliest next `start` is sampled at D+1.
- `in_valid` gaps in ACCUM stall the count without penalty. Throughput is one chunk per cycle.
- `NUM_CHUNKS`=1: the single beat goes straight to DONE.
- All outputs are registered. No combinational path from `in_data` to any output.

## Configuration
- `MIN_REDUCE_IDX_EN` defined:
  - Index tracking is compiled in.
  - The chunk-min stage produces the local index.
  - `out_idx` reports the global position of the minimum.
- `MIN_REDUCE_IDX_EN` undefined:
  - Index logic and registers are removed.
  - `out_idx` is tied to 0.
  - `out_min`, handshakes and timing are identical.

## Structure
- Shared package `min_pkg`:
  - State enum (IDLE=0, ACCUM=1, DONE=2), 2 bits.
  - Most-positive-value constant as a function of `DATA_WIDTH`.
  - Index-width helper (`$clog2`, floor 1).
- One sub-module, `chunk_min`:
  - Combinational comparison tree over `CHUNK_LEN` signed lanes.
  - Outputs the min value and, under `MIN_REDUCE_IDX_EN`, the lowest-lane index.
- The controller holds the FSM, `chunk_cnt`, the running registers and the handshake logic.

## Test plan
- Defaults, beats {5,9,3,7,8,6,4,10}, {20…27}, {-2,1,1,1,1,1,1,1}, {0…7}, `in_valid` constant → `out_min`=-2, `out_idx`=16, `out_valid` at start+5.
- Ties: every element = 3 → `out_min`=3, `out_idx`=0. Then lanes 5 and 13 = 1 → `out_idx`=5.
- Backpressure:
  - `in_valid` toggles every other cycle → same result, `out_valid` at start+9.
  - `out_ready` low 4 cycles in DONE → outputs held stable, `start` ignored throughout.
- Extremes: all -32768 → `out_min`=-32768, `out_idx`=0. All 32767 → `out_min`=32767, `out_idx`=0.
- `rst` asserted after beat 2 → next cycle IDLE, `out_valid`=0, `busy`=0. A fresh run then gives correct results with no stale minimum.
- `MIN_REDUCE_IDX_EN` undefined → first scenario gives `out_min`=-2, `out_idx`=0, same cycle counts.
